// File: rtl/lp_alu_ret.sv
// lp_alu_ret: power-gated ALU with a result retention register and output isolation.
//
// Single-cycle ops (ADD..SRL) finish one edge after acceptance; MUL, DIV and REM latch their
// operands and complete after MUL_LAT / DIV_LAT cycles. The retention register survives the
// ALU domain being powered down. While powered down or isolated, the result port shows the
// retained value (or ISO_VAL if nothing has been saved).
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   A, B         operands (WIDTH bits)
//   opcode       0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 MUL, 9 DIV, 10 REM
//   start        operation request (taken only in IDLE, powered, not isolated)
//   alu_pwr_en   1 = ALU domain powered; 0 aborts work and clears the result register
//   iso_en       1 = clamp result port
//   save         copy result register into the retention register
//   restore      copy retention register back into the result register (wins over save)
//   result       isolated result port
//   result_valid one-cycle completion pulse
//   busy         multi-cycle operation in flight
//   err          one-cycle pulse on illegal opcode or divide by zero
//   ret_valid    retention register holds saved data
module lp_alu_ret #(
    parameter int unsigned      WIDTH   = 16,
    parameter int unsigned      MUL_LAT = 4,
    parameter int unsigned      DIV_LAT = 8,
    parameter logic [WIDTH-1:0] ISO_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    input  logic             start,
    input  logic             alu_pwr_en,
    input  logic             iso_en,
    input  logic             save,
    input  logic             restore,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             err,
    output logic             ret_valid
);

    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL_EXEC, DIV_EXEC} state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_is_rem;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_ret;
    logic             r_ret_valid;
    logic             r_valid;
    logic             r_err;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [3:0]       w_cnt_nxt;
    logic [WIDTH-1:0] w_op_a_nxt;
    logic [WIDTH-1:0] w_op_b_nxt;
    logic             w_is_rem_nxt;
    logic [WIDTH-1:0] w_result_nxt;
    logic [WIDTH-1:0] w_ret_nxt;
    logic             w_ret_valid_nxt;
    logic             w_valid_nxt;
    logic             w_err_nxt;
    logic             w_busy_nxt;

    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_mul;
    logic             w_div0;
    logic [WIDTH-1:0] w_div_res;

    assign w_shamt = B[SHW-1:0];
    // Same-width operands and result keep only the low WIDTH bits of the product.
    assign w_mul   = r_op_a * r_op_b;
    assign w_div0  = (r_op_b == '0);

    always_comb begin
        w_div_res = '0;
        if (r_is_rem) begin
            w_div_res = w_div0 ? r_op_a : (r_op_a % r_op_b);
        end else begin
            w_div_res = w_div0 ? '1 : (r_op_a / r_op_b);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_op_a_nxt      = r_op_a;
        w_op_b_nxt      = r_op_b;
        w_is_rem_nxt    = r_is_rem;
        w_result_nxt    = r_result;
        w_ret_nxt       = r_ret;
        w_ret_valid_nxt = r_ret_valid;
        w_valid_nxt     = 1'b0;
        w_err_nxt       = 1'b0;
        w_busy_nxt      = r_busy;

        if (!alu_pwr_en) begin
            // Power loss: drop in-flight work and unretained state; retention is kept.
            w_state_nxt  = IDLE;
            w_cnt_nxt    = '0;
            w_busy_nxt   = 1'b0;
            w_result_nxt = '0;
        end else begin
            if (!r_busy) begin
                if (restore) begin
                    if (r_ret_valid) begin
                        w_result_nxt = r_ret;
                    end
                end else if (save) begin
                    w_ret_nxt       = r_result;
                    w_ret_valid_nxt = 1'b1;
                end
            end

            unique case (r_state)
                IDLE: begin
                    w_cnt_nxt = '0;
                    if (start && !iso_en) begin
                        case (opcode)
                            4'd0: begin w_result_nxt = A + B;         w_valid_nxt = 1'b1; end
                            4'd1: begin w_result_nxt = A - B;         w_valid_nxt = 1'b1; end
                            4'd2: begin w_result_nxt = A & B;         w_valid_nxt = 1'b1; end
                            4'd3: begin w_result_nxt = A | B;         w_valid_nxt = 1'b1; end
                            4'd4: begin w_result_nxt = A ^ B;         w_valid_nxt = 1'b1; end
                            4'd5: begin w_result_nxt = ~(A | B);      w_valid_nxt = 1'b1; end
                            4'd6: begin w_result_nxt = A << w_shamt;  w_valid_nxt = 1'b1; end
                            4'd7: begin w_result_nxt = A >> w_shamt;  w_valid_nxt = 1'b1; end
                            4'd8, 4'd9, 4'd10: begin
                                w_op_a_nxt   = A;
                                w_op_b_nxt   = B;
                                w_is_rem_nxt = (opcode == 4'd10);
                                w_busy_nxt   = 1'b1;
                                w_state_nxt  = (opcode == 4'd8) ? MUL_EXEC : DIV_EXEC;
                            end
                            default: w_err_nxt = 1'b1;
                        endcase
                    end
                end
                MUL_EXEC: begin
                    if (r_cnt == 4'(MUL_LAT - 1)) begin
                        w_result_nxt = w_mul;
                        w_valid_nxt  = 1'b1;
                        w_busy_nxt   = 1'b0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                DIV_EXEC: begin
                    if (r_cnt == 4'(DIV_LAT - 1)) begin
                        w_result_nxt = w_div_res;
                        w_valid_nxt  = 1'b1;
                        w_err_nxt    = w_div0;
                        w_busy_nxt   = 1'b0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_is_rem    <= 1'b0;
            r_result    <= '0;
            r_ret       <= '0;
            r_ret_valid <= 1'b0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_op_a      <= w_op_a_nxt;
            r_op_b      <= w_op_b_nxt;
            r_is_rem    <= w_is_rem_nxt;
            r_result    <= w_result_nxt;
            r_ret       <= w_ret_nxt;
            r_ret_valid <= w_ret_valid_nxt;
            r_valid     <= w_valid_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign result       = (iso_en || !alu_pwr_en) ? (r_ret_valid ? r_ret : ISO_VAL) : r_result;
    assign result_valid = r_valid;
    assign busy         = r_busy;
    assign err          = r_err;
    assign ret_valid    = r_ret_valid;

endmodule

// File: doc/lp_alu_ret.md
LP_ALU_RET -- requirements
Module: lp_alu_ret

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand/result width (8..32).
REQ-002 SHALL provide parameter MUL_LAT, default 4, MUL latency in cycles (2..15).
REQ-003 SHALL provide parameter DIV_LAT, default 8, DIV/REM latency in cycles (2..15).
REQ-004 SHALL provide parameter ISO_VAL, default 0, WIDTH-bit clamp value when no retained data exists.
REQ-005 SHALL have ports, in this order:
  clk  in  1  clock; one clock domain, all logic on rising edge
  rst  in  1  reset, synchronous, active-high
  A  in  WIDTH  operand A
  B  in  WIDTH  operand B
  opcode  in  4  operation select
  start  in  1  operation request
  alu_pwr_en  in  1  1 = ALU domain powered
  iso_en  in  1  1 = clamp result port
  save  in  1  capture result into retention register
  restore  in  1  reload result from retention register
  result  out  WIDTH  result port (isolated)
  result_valid  out  1  one-cycle completion pulse
  busy  out  1  multi-cycle operation in flight
  err  out  1  one-cycle error pulse (illegal opcode or divide by zero)
  ret_valid  out  1  retention register holds saved data

Function
REQ-006 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 MUL, 9 DIV, 10 REM; 11-15 illegal.
REQ-007 ADD/SUB/MUL SHALL wrap modulo 2^WIDTH (MUL keeps low WIDTH bits); shifts SHALL use B[clog2(WIDTH)-1:0]; DIV/REM SHALL be unsigned.
REQ-008 start SHALL be accepted only when state IDLE, alu_pwr_en=1, iso_en=0; otherwise ignored with no output change.
REQ-009 Opcodes 0-7 accepted at edge k: result register updated and result_valid=1 after edge k; busy stays 0.
REQ-010 Opcodes 8-10: A, B, opcode latched at edge k; busy=1 after edges k..k+LAT-1; at edge k+LAT result updated, result_valid=1, busy=0.
REQ-011 Operand inputs changing while busy SHALL NOT affect the result.
REQ-012 FSM states SHALL be IDLE, MUL_EXEC, DIV_EXEC; per-op cycle counter cleared in IDLE; return to IDLE on final cycle.
REQ-013 Divide by zero: DIV result all-ones, REM result A, err=1 with result_valid.
REQ-014 Illegal opcode accepted: err=1 for one cycle, result_valid=0, result register unchanged.
REQ-015 save SHALL capture the result register into the retention register only when alu_pwr_en=1 and busy=0; sets ret_valid=1; save while busy ignored.
REQ-016 restore with alu_pwr_en=1, busy=0, ret_valid=1 SHALL load retention register into result register next edge; no result_valid pulse; otherwise ignored.
REQ-017 save and restore in the same cycle: restore wins, save ignored.
REQ-018 alu_pwr_en=0 SHALL abort any in-flight op (busy=0 next edge, no result_valid/err), force FSM to IDLE and clear result register to 0 (unretained state lost); retention register and ret_valid keep value.
REQ-019 result port SHALL equal retention register if ret_valid else ISO_VAL whenever iso_en=1 or alu_pwr_en=0; otherwise equal result register.
REQ-020 result_valid, err SHALL be registered single-cycle pulses; busy registered.

Reset
REQ-021 rst=1 at an edge SHALL clear result register, retention register, ret_valid, result_valid, busy, err, counter, and FSM to IDLE, overriding all other inputs including mid-operation.
REQ-022 After reset with iso_en=0 and alu_pwr_en=1, result SHALL read 0.

Verification
REQ-023 WIDTH=16: ADD A=0xFFFF B=0x0002 start -> next cycle result=0x0001, result_valid=1 one cycle, busy=0.
REQ-024 MUL A=0x0100 B=0x0300, MUL_LAT=4 -> busy 4 cycles, result=0x0000 with result_valid at 4th edge; start during busy ignored.
REQ-025 DIV A=100 B=0 -> after 8 cycles result=0xFFFF, err=1, result_valid=1; REM A=100 B=7 -> result=2.
REQ-026 result=0x1234, save, drop alu_pwr_en mid-DIV with iso_en=1 -> busy clears, result port=0x1234; repower, restore -> result=0x1234 with iso_en=0.
REQ-027 save and restore same cycle with ret_valid=0 -> ret_valid stays 0; iso_en=1 -> result=ISO_VAL.
REQ-028 rst asserted at cycle 3 of MUL -> busy=0, result=0, no result_valid thereafter.
